// File: rtl/mac_dot_seq.sv
// Sequencer that streams operand pairs through an external pipelined MAC and
// reduces MAC_LAT interleaved partial sums into one unsigned dot product per job.
module mac_dot_seq #(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic [15:0]      mac_a,
    output logic [15:0]      mac_b,
    output logic [31:0]      mac_acc,
    input  logic [31:0]      mac_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data
);

    localparam int unsigned AW = 32;
    localparam int unsigned PW = $clog2(MAC_LAT + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count_q;
    logic [PW-1:0]    phase_q;
    logic [AW-1:0]    red_q;
    logic [AW-1:0]    red_d;
    logic [AW-1:0]    res_data_q;
    logic             accept;
    logic             phase_last;

    assign accept     = (state_q == S_RUN) && in_valid;
    assign phase_last = (phase_q == PW'(MAC_LAT - 1));
    assign red_d      = red_q + mac_out;

    // Only RUN drives real operands; every other state issues zero ops with acc=0.
    assign mac_a   = accept ? in_a : '0;
    assign mac_b   = accept ? in_b : '0;
    assign mac_acc = (state_q == S_RUN) ? mac_out : '0;

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_RUN);
    assign res_valid = (state_q == S_DONE);
    assign res_data  = res_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            len_q      <= '0;
            count_q    <= '0;
            phase_q    <= '0;
            red_q      <= '0;
            res_data_q <= '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    if (phase_last) begin
                        phase_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        count_q <= '0;
                        red_q   <= '0;
                        phase_q <= '0;
                        state_q <= (len == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        count_q <= count_q + LEN_W'(1);
                        if (count_q == len_q - LEN_W'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The last op of each circulating slot lands here, one slot per cycle.
                    red_q <= red_d;
                    if (phase_last) begin
                        phase_q    <= '0;
                        res_data_q <= red_d;
                        state_q    <= S_DONE;
                    end else begin
                        phase_q <= phase_q + PW'(1);
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq: attaches a 3-cycle MAC model, checks every cycle against
// an event-level reference, and pins the reference with hand-computed results.
module tb_mac_dot_seq;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned MAC_LAT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [31:0]      mac_acc;
    logic [31:0]      mac_out;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;

    always #5 clk = ~clk;

    mac_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Unreset MAC with junk in its pipe, so only the INIT flush can clear it.
    logic [31:0] p0 = 32'hDEAD_BEEF;
    logic [31:0] p1 = 32'h1234_5678;
    logic [31:0] p2 = 32'hCAFE_F00D;
    always @(posedge clk) begin
        p0 <= 32'(mac_a) * 32'(mac_b) + mac_acc;
        p1 <= p0;
        p2 <= p1;
    end
    assign mac_out = p2;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    // Reference: job-level events with cycle stamps, not a copy of the DUT states.
    int          cyc        = 0;
    int          idle_cycle = 0;
    int          res_cycle  = 0;
    int          m_left     = 0;
    bit          m_ok       = 1'b0;
    bit          m_job      = 1'b0;
    bit          m_stream   = 1'b0;
    logic [31:0] m_sum      = '0;
    logic [31:0] m_res      = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ok       = 1'b1;
            m_job      = 1'b0;
            m_stream   = 1'b0;
            m_res      = '0;
            idle_cycle = cyc + MAC_LAT + 1;
        end else begin
            if (!m_job && cyc >= idle_cycle) begin
                if (start) begin
                    m_job    = 1'b1;
                    m_sum    = '0;
                    m_left   = int'(len);
                    m_stream = (len != '0);
                    if (len == '0) res_cycle = cyc + MAC_LAT + 1;
                end
            end else if (m_stream) begin
                if (in_valid) begin
                    m_sum += 32'(in_a) * 32'(in_b);
                    m_left--;
                    if (m_left == 0) begin
                        m_stream  = 1'b0;
                        res_cycle = cyc + MAC_LAT + 1;
                    end
                end
            end else if (m_job && cyc >= res_cycle && res_ready) begin
                m_job = 1'b0;
            end
            if (m_job && !m_stream && cyc + 1 == res_cycle) m_res = m_sum;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (!rst && m_ok) begin
            check("busy", 32'(busy), 32'((cyc < idle_cycle) || m_job));
            check("in_ready", 32'(in_ready), 32'(m_stream));
            check("res_valid", 32'(res_valid), 32'(m_job && !m_stream && cyc >= res_cycle));
            check("res_data", res_data, m_res);
            check("mac_a", 32'(mac_a), (m_stream && in_valid) ? 32'(in_a) : 32'd0);
            check("mac_b", 32'(mac_b), (m_stream && in_valid) ? 32'(in_b) : 32'd0);
            check("mac_acc", mac_acc, m_stream ? mac_out : 32'd0);
        end
    end

    logic [15:0] va [256];
    logic [15:0] vb [256];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap<0: random in_valid; pulse: toggle start while the result is held and at handshake.
    task automatic run_job(input int n, input int gap, input logic [31:0] want, input bit use_want,
                           input int hold, input bit pulse);
        int          w = 0;
        int          i = 0;
        int          lat;
        logic [31:0] sum = '0;
        for (int k = 0; k < n; k++) sum += 32'(va[k]) * 32'(vb[k]);
        while (busy && w < 100) begin tick(); w++; end
        if (busy) check("idle_wait", 32'(busy), 32'd0);
        start = 1'b1;
        len   = LEN_W'(n);
        tick();
        start = 1'b0;
        while (i < n && w < 5000) begin
            if (gap < 0) begin
                in_valid = ($urandom % 3) != 0;
            end else begin
                in_valid = 1'b1;
                if (i > 0) begin
                    for (int g = 0; g < gap; g++) begin
                        in_valid = 1'b0;
                        in_a = 16'($urandom);
                        in_b = 16'($urandom);
                        tick();
                    end
                    in_valid = 1'b1;
                end
            end
            in_a = in_valid ? va[i] : 16'($urandom);
            in_b = in_valid ? vb[i] : 16'($urandom);
            tick();
            if (in_valid) i++;
            w++;
        end
        in_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 50) begin tick(); lat++; end
        check("latency", 32'(lat), 32'(MAC_LAT + 1));
        check("result_model", res_data, sum);
        if (use_want) check("result_lit", res_data, want);
        for (int h = 0; h < hold; h++) begin
            start = pulse ? 1'($urandom % 2) : 1'b0;
            len   = LEN_W'($urandom);
            tick();
        end
        res_ready = 1'b1;
        start     = pulse;
        tick();
        res_ready = 1'b0;
        start     = 1'b0;
        check("post_handshake_idle", 32'(busy), 32'd0);
    endtask

    task automatic set4(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
        va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
        vb[0] = b0; vb[1] = b1; vb[2] = b2; vb[3] = b3;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_res_data", res_data, 32'd0);

        set4(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        run_job(4, 0, 32'd70, 1'b1, 0, 1'b0);
        run_job(4, 1, 32'd70, 1'b1, 0, 1'b0);
        run_job(4, 2, 32'd70, 1'b1, 0, 1'b0);
        run_job(4, 5, 32'd70, 1'b1, 0, 1'b0);

        set4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0);
        run_job(1, 0, 32'hFFFE_0001, 1'b1, 0, 1'b0);
        run_job(0, 0, 32'd0, 1'b1, 0, 1'b0);
        run_job(3, 0, 32'hFFFA_0003, 1'b1, 2, 1'b0);

        set4(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        run_job(4, 0, 32'd70, 1'b1, 10, 1'b1);
        set4(16'd2, 16'd3, 16'd0, 16'd0, 16'd10, 16'd100, 16'd0, 16'd0);
        run_job(2, 0, 32'd320, 1'b1, 0, 1'b0);

        // Abort a job halfway with reset.
        set4(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8);
        start = 1'b1; len = LEN_W'(4);
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start = (k == 0);
            len   = LEN_W'(5);
            check("init_busy", 32'(busy), 32'd1);
            check("init_in_ready", 32'(in_ready), 32'd0);
            check("init_res_valid", 32'(res_valid), 32'd0);
            check("init_res_data", res_data, 32'd0);
            check("init_mac", {mac_a, mac_b} | mac_acc, 32'd0);
            tick();
        end
        start = 1'b0;
        check("init_to_idle", 32'(busy), 32'd0);
        set4(16'd7, 16'd1, 16'd0, 16'd0, 16'd6, 16'd1, 16'd0, 16'd0);
        run_job(2, 0, 32'd43, 1'b1, 0, 1'b0);

        for (int j = 0; j < 255; j++) begin
            va[j] = 16'hFFFF - 16'(j);
            vb[j] = 16'hFFFF;
        end
        run_job(255, 0, 32'd0, 1'b0, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            int n;
            n = int'($urandom_range(0, 12));
            for (int j = 0; j < n; j++) begin
                va[j] = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
                vb[j] = ($urandom % 4 == 0) ? 16'hFFFF : 16'($urandom);
            end
            run_job(n, -1, 32'd0, 1'b0, int'($urandom_range(0, 3)), 1'($urandom % 2));
        end

        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
